// File: rtl/arrisc_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : arrisc_pkg                                                        |
// | Brief  : Shared fetch-path types and constants: machine/instruction widths,|
// |          the canonical NOP encoding and the fetch response record.         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package arrisc_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  // addi x0, x0, 0 -- returned in place of ROM data for faulting fetches
  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] addr;
    logic            fault;
  } fetch_resp_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// +----------------------------------------------------------------------------+
// | Module : sync_fifo                                                         |
// | Brief  : Show-ahead synchronous FIFO. Head entry is presented on pop_data  |
// |          whenever empty=0. Pointers carry one extra wrap bit so full and   |
// |          empty are told apart by the MSB compare. clear empties the queue  |
// |          synchronously and overrides push/pop in the same cycle.           |
// | Ports  : clk, rst_n (async, active low), clear, push/push_data,            |
// |          pop/pop_data, full, empty. DEPTH must be a power of 2, >= 2.      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [c_AW:0]      r_wr_ptr;
  logic [c_AW:0]      r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_do_push;
  logic               w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                 (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

  assign w_do_push = push && !full  && !clear;
  assign w_do_pop  = pop  && !empty && !clear;

  assign pop_data = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
    end
  end

  // Storage needs no reset: nothing is visible until a push has written it.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/instr_mem_responder.sv
// +----------------------------------------------------------------------------+
// | Module : instr_mem_responder                                               |
// | Brief  : Instruction-fetch responder. Accepts PC fetch requests, returns   |
// |          the ROM word LATENCY cycles later through a credit-managed        |
// |          show-ahead queue. Misaligned / out-of-range fetches return a NOP  |
// |          with resp_fault set. flush drops everything outstanding.          |
// | Ports  : clk, rst_n (async, active low), flush,                            |
// |          req_valid/req_ready/req_addr  (fetch request),                    |
// |          resp_valid/resp_ready/resp_instr/resp_addr/resp_fault (response). |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module instr_mem_responder
  import arrisc_pkg::*;
#(
  parameter int    WORDS     = 1024,
  parameter string INIT_FILE = "",
  parameter int    LATENCY   = 2,
  parameter int    DEPTH     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [ILEN-1:0] resp_instr,
  output logic [XLEN-1:0] resp_addr,
  output logic            resp_fault
);

  localparam int                c_IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int                c_CNT_W     = $clog2(DEPTH) + 1;
  localparam int                c_STAGES    = LATENCY - 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
  localparam logic [XLEN-1:0]   c_WORDS_X   = XLEN'(WORDS);

  logic [ILEN-1:0]    r_rom [WORDS];

  logic [c_CNT_W-1:0] r_count;
  logic               w_accept;
  logic               w_pop;
  logic               w_req_fault;
  logic               w_push;
  logic [XLEN-1:0]    w_push_addr;
  logic               w_push_fault;
  logic [c_IDX_W-1:0] w_push_idx;
  fetch_resp_t        w_push_entry;
  fetch_resp_t        w_head;
  logic               w_fifo_full;
  logic               w_fifo_empty;

  // Ready is derived from the registered credit count only, so there is no
  // combinational path from resp_ready back to req_ready.
  assign req_ready = rst_n && !flush && (r_count < c_DEPTH_CNT);
  assign w_accept  = req_valid && req_ready;
  assign w_pop     = resp_valid && resp_ready;

  assign w_req_fault = (req_addr[1:0] != 2'b00) ||
                       ({2'b00, req_addr[XLEN-1:2]} >= c_WORDS_X);

  // Outstanding credit: covers both the delay line and the queue, which is
  // what guarantees a queue slot for every entry leaving the delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_accept && !w_pop) begin
      r_count <= r_count + c_CNT_W'(1);
    end else if (!w_accept && w_pop) begin
      r_count <= r_count - c_CNT_W'(1);
    end
  end

  // Delay line: LATENCY-1 stages; the queue write itself is the registered
  // ROM read, so the head becomes poppable LATENCY edges after accept.
  generate
    if (LATENCY == 1) begin : g_no_pipe
      assign w_push       = w_accept;
      assign w_push_addr  = req_addr;
      assign w_push_fault = w_req_fault;
    end else begin : g_pipe
      logic [c_STAGES-1:0] r_valid;
      logic [c_STAGES-1:0] r_fault;
      logic [XLEN-1:0]     r_addr [c_STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= '0;
        end else if (flush) begin
          r_valid <= '0;
        end else begin
          for (int i = c_STAGES - 1; i > 0; i--) r_valid[i] <= r_valid[i-1];
          r_valid[0] <= w_accept;
        end
      end

      always_ff @(posedge clk) begin
        for (int i = c_STAGES - 1; i > 0; i--) begin
          r_addr[i]  <= r_addr[i-1];
          r_fault[i] <= r_fault[i-1];
        end
        r_addr[0]  <= req_addr;
        r_fault[0] <= w_req_fault;
      end

      assign w_push       = r_valid[c_STAGES-1];
      assign w_push_addr  = r_addr[c_STAGES-1];
      assign w_push_fault = r_fault[c_STAGES-1];
    end
  endgenerate

  assign w_push_idx = w_push_addr[2+c_IDX_W-1:2];

  // Faulting fetches never index the ROM; the NOP is substituted instead.
  always_comb begin
    w_push_entry.addr  = w_push_addr;
    w_push_entry.fault = w_push_fault;
    w_push_entry.instr = w_push_fault ? INSTR_NOP : r_rom[w_push_idx];
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_resp_t)),
    .DEPTH (DEPTH)
  ) u_resp_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (w_push && !w_fifo_full),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  // Data outputs read as zero whenever no response is presented, which also
  // gives the all-zero output state while reset is held.
  assign resp_valid = !w_fifo_empty;
  assign resp_instr = resp_valid ? w_head.instr : '0;
  assign resp_addr  = resp_valid ? w_head.addr  : '0;
  assign resp_fault = resp_valid && w_head.fault;

endmodule

`default_nettype wire
